// File: rtl/row_slider_pkg.sv
// row_slider_pkg: shared board width, state encoding and direction constants
package row_slider_pkg;
    localparam int BOARD_W_DEF = 16;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SLIDE   = 2'd1,
        RESOLVE = 2'd2
    } state_t;
    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;
endpackage

// File: rtl/row_slider_frame_divider.sv
// row_slider_frame_divider: counts frame ticks and pulses step once per period
module row_slider_frame_divider (
    input  logic        clk,
    input  logic        resetn,
    input  logic        clear,
    input  logic        en,
    input  logic        tick,
    input  logic [10:0] period,
    output logic        step
);
    logic [10:0] r_cnt;
    assign step = en && tick && (r_cnt == period - 11'd1);
    // frame counter: wraps to zero on the stepping tick, cleared when a row starts
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_cnt <= '0;
        else if (clear) r_cnt <= '0;
        else if (en && tick) r_cnt <= step ? 11'd0 : r_cnt + 11'd1;
    end
endmodule

// File: rtl/row_slider.sv
// row_slider: bouncing row that the player drops onto the surviving base
module row_slider
    import row_slider_pkg::*;
#(
    parameter int BOARD_W = BOARD_W_DEF
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               frame_tick,
    input  logic               start,
    input  logic               drop,
    input  logic [10:0]        speed_count,
    input  logic [3:0]         num_blocks,
    output logic [BOARD_W-1:0] row_mask,
    output logic [BOARD_W-1:0] base_mask,
    output logic               busy,
    output logic               next_signal,
    output logic               fail
);
    localparam int PW = (BOARD_W > 1) ? $clog2(BOARD_W) : 1;
    state_t             r_state, w_state_next;
    logic [PW-1:0]      r_pos;
    logic               r_dir;
    logic [3:0]         r_width;
    logic [10:0]        r_period;
    logic [BOARD_W-1:0] r_base, w_row, w_overlap;
    logic               r_next, r_fail, w_step, w_begin, w_hold, w_at_right;
    int                 w_lo, w_wd;
    assign w_begin    = (r_state == IDLE) && start;
    assign w_lo       = int'(r_pos);
    assign w_wd       = int'(r_width);
    assign w_hold     = w_wd >= BOARD_W;
    assign w_at_right = w_lo >= BOARD_W - w_wd;
    assign w_overlap  = w_row & r_base;
    assign row_mask    = w_row;
    assign base_mask   = r_base;
    assign busy        = r_state != IDLE;
    assign next_signal = r_next;
    assign fail        = r_fail;
    row_slider_frame_divider u_frame_divider (
        .clk    (clk),
        .resetn (resetn),
        .clear  (w_begin),
        .en     (r_state == SLIDE),
        .tick   (frame_tick),
        .period (r_period),
        .step   (w_step)
    );
    // moving row decoded from registered position and width; blank when idle
    always_comb begin
        w_row = '0;
        for (int i = 0; i < BOARD_W; i++) w_row[i] = (r_state != IDLE) && (i >= w_lo) && (i < w_lo + w_wd);
    end
    // next state: resolve always lasts exactly one cycle
    always_comb begin
        w_state_next = r_state;
        w_state_next = w_begin ? SLIDE :
                       (r_state == SLIDE && drop) ? RESOLVE :
                       (r_state == RESOLVE) ? IDLE : r_state;
    end
    // state, row geometry, bounce motion, and drop resolution against the base
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= IDLE;
            r_pos    <= '0;
            r_dir    <= DIR_RIGHT;
            r_width  <= 4'd1;
            r_period <= 11'd1;
            r_base   <= '1;
            r_next   <= 1'b0;
            r_fail   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_next  <= 1'b0;
            r_fail  <= 1'b0;
            if (w_begin) begin
                r_width  <= (num_blocks == 4'd0) ? 4'd1 : num_blocks;
                r_period <= (speed_count == 11'd0) ? 11'd1 : speed_count;
                r_pos    <= '0;
                r_dir    <= DIR_RIGHT;
            end else if (r_state == SLIDE && !drop && w_step) begin
                if (w_hold) r_pos <= '0;
                else if (r_dir == DIR_RIGHT) begin
                    r_dir <= w_at_right ? DIR_LEFT : DIR_RIGHT;
                    r_pos <= w_at_right ? r_pos - 1'b1 : r_pos + 1'b1;
                end else begin
                    r_dir <= (r_pos == '0) ? DIR_RIGHT : DIR_LEFT;
                    r_pos <= (r_pos == '0) ? r_pos + 1'b1 : r_pos - 1'b1;
                end
            end
            if (r_state == RESOLVE) begin
                r_next <= |w_overlap;
                r_fail <= ~|w_overlap;
                r_base <= (|w_overlap) ? w_overlap : '1;
            end
        end
    end
endmodule

// File: tb/tb_row_slider.sv
// tb_row_slider: scoreboard-driven checks of sliding, bouncing, drop resolution and reset
module tb_row_slider;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        frame_tick = 1'b0;
    logic        start = 1'b0;
    logic        drop = 1'b0;
    logic [10:0] speed_count = 11'd1;
    logic [3:0]  num_blocks = 4'd1;
    logic [15:0] row_mask, base_mask;
    logic        busy, next_signal, fail;

    typedef struct packed {
        logic        is_next;
        logic [15:0] base;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] m_base;
    int          checks = 0;
    int          failures = 0;
    int          pulse_cnt = 0;

    row_slider dut (
        .clk         (clk),
        .resetn      (resetn),
        .frame_tick  (frame_tick),
        .start       (start),
        .drop        (drop),
        .speed_count (speed_count),
        .num_blocks  (num_blocks),
        .row_mask    (row_mask),
        .base_mask   (base_mask),
        .busy        (busy),
        .next_signal (next_signal),
        .fail        (fail)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (next_signal || fail) pulse_cnt++;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        cyc();
        cyc();
        resetn = 1'b1;
        m_base = 16'hFFFF;
        cyc();
    endtask

    task automatic do_start(input logic [3:0] nb, input logic [10:0] sc);
        num_blocks = nb;
        speed_count = sc;
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic do_tick();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
    endtask

    task automatic check_row(input string name, input logic [15:0] exp);
        checks++;
        if (row_mask !== exp) begin
            failures++;
            $display("FAIL %s: row_mask=%h expected %h", name, row_mask, exp);
        end
    endtask

    task automatic do_drop(input string name, input logic [15:0] exp_row, input logic with_tick);
        exp_t e;
        logic [15:0] ov;
        ov = exp_row & m_base;
        e.is_next = ov != 16'h0;
        e.base = (ov != 16'h0) ? ov : 16'hFFFF;
        sb.push_back(e);
        drop = 1'b1;
        frame_tick = with_tick;
        cyc();
        drop = 1'b0;
        frame_tick = 1'b0;
        checks++;
        if (next_signal !== 1'b0 || fail !== 1'b0 || busy !== 1'b1 || row_mask !== exp_row) begin
            failures++;
            $display("FAIL %s_resolve: next=%b fail=%b busy=%b row=%h expected 0 0 1 %h",
                     name, next_signal, fail, busy, row_mask, exp_row);
        end
        cyc();
        e = sb.pop_front();
        checks++;
        if (next_signal !== e.is_next || fail !== !e.is_next) begin
            failures++;
            $display("FAIL %s_pulse: next=%b fail=%b expected next=%b fail=%b",
                     name, next_signal, fail, e.is_next, !e.is_next);
        end
        checks++;
        if (base_mask !== e.base) begin
            failures++;
            $display("FAIL %s_base: base_mask=%h expected %h", name, base_mask, e.base);
        end
        checks++;
        if (busy !== 1'b0 || row_mask !== 16'h0) begin
            failures++;
            $display("FAIL %s_idle: busy=%b row=%h expected 0 0000", name, busy, row_mask);
        end
        m_base = e.base;
        cyc();
        checks++;
        if (next_signal !== 1'b0 || fail !== 1'b0) begin
            failures++;
            $display("FAIL %s_pulse_end: next=%b fail=%b expected 0 0", name, next_signal, fail);
        end
    endtask

    task automatic test_reset();
        int p0;
        apply_reset();
        checks++;
        if (row_mask !== 16'h0 || base_mask !== 16'hFFFF || busy !== 1'b0 || next_signal !== 1'b0 || fail !== 1'b0) begin
            failures++;
            $display("FAIL reset: row=%h base=%h busy=%b next=%b fail=%b expected 0000 ffff 0 0 0",
                     row_mask, base_mask, busy, next_signal, fail);
        end
        p0 = pulse_cnt;
        drop = 1'b1;
        cyc();
        drop = 1'b0;
        cyc();
        cyc();
        checks++;
        if (busy !== 1'b0 || pulse_cnt != p0) begin
            failures++;
            $display("FAIL drop_in_idle: busy=%b pulses=%0d expected 0 %0d", busy, pulse_cnt, p0);
        end
    endtask

    task automatic test_slide();
        do_start(4'd3, 11'd2);
        check_row("slide_start", 16'h0007);
        do_tick();
        check_row("slide_tick1", 16'h0007);
        do_tick();
        check_row("slide_tick2", 16'h000E);
        do_start(4'd1, 11'd1);
        check_row("start_in_slide", 16'h000E);
        do_tick();
        check_row("slide_tick3", 16'h000E);
        do_tick();
        check_row("slide_tick4", 16'h001C);
        do_drop("drop_next", 16'h001C, 1'b0);
    endtask

    task automatic test_bounce();
        do_start(4'd15, 11'd1);
        check_row("bounce_start", 16'h7FFF);
        do_tick();
        check_row("bounce_t1", 16'hFFFE);
        do_tick();
        check_row("bounce_t2", 16'h7FFF);
        do_tick();
        check_row("bounce_t3", 16'hFFFE);
        do_drop("bounce_drop", 16'hFFFE, 1'b0);
    endtask

    task automatic test_zero_params();
        do_start(4'd0, 11'd0);
        check_row("zero_width", 16'h0001);
        do_tick();
        check_row("zero_period_step", 16'h0002);
        do_drop("zero_drop", 16'h0002, 1'b0);
    endtask

    task automatic test_drop_fail();
        apply_reset();
        do_start(4'd4, 11'd1);
        do_drop("make_base", 16'h000F, 1'b0);
        do_start(4'd4, 11'd1);
        for (int i = 0; i < 4; i++) do_tick();
        check_row("fail_row", 16'h00F0);
        do_drop("drop_fail", 16'h00F0, 1'b0);
    endtask

    task automatic test_back_to_back();
        int p0;
        do_start(4'd3, 11'd1);
        check_row("coinc_row", 16'h0007);
        do_drop("drop_with_step", 16'h0007, 1'b1);
        do_start(4'd3, 11'd1);
        do_tick();
        check_row("pre_reset_row", 16'h000E);
        p0 = pulse_cnt;
        drop = 1'b1;
        cyc();
        drop = 1'b0;
        resetn = 1'b0;
        #1;
        checks++;
        if (row_mask !== 16'h0 || busy !== 1'b0 || base_mask !== 16'hFFFF || next_signal !== 1'b0 || fail !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: row=%h busy=%b base=%h next=%b fail=%b expected 0000 0 ffff 0 0",
                     row_mask, busy, base_mask, next_signal, fail);
        end
        cyc();
        cyc();
        resetn = 1'b1;
        m_base = 16'hFFFF;
        cyc();
        cyc();
        checks++;
        if (pulse_cnt != p0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_discard: pulses=%0d busy=%b expected %0d 0", pulse_cnt, busy, p0);
        end
    endtask

    initial begin
        m_base = 16'hFFFF;
        test_reset();
        test_slide();
        test_bounce();
        test_zero_params();
        test_drop_fail();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_empty: left=%0d expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/row_slider.md
ROW_SLIDER -- requirements
Module: row_slider

Interface
REQ-001 Parameter BOARD_W, default 16: board columns; row and base masks are BOARD_W bits wide.
REQ-002 clk  in  1  system clock; all state changes on its rising edge.
REQ-003 resetn  in  1  one clock; reset is asynchronous and active-low.
REQ-004 frame_tick  in  1  one-cycle pulse per display frame (60 Hz).
REQ-005 start  in  1  one-cycle pulse: begin sliding a new row.
REQ-006 drop  in  1  one-cycle pulse: player locks the moving row.
REQ-007 speed_count  in  11  frame ticks per one-column step, from level FSM.
REQ-008 num_blocks  in  4  moving row width in blocks, from level FSM.
REQ-009 row_mask  out  BOARD_W  current moving row; bit i = column i.
REQ-010 base_mask  out  BOARD_W  surviving columns of the last placed row.
REQ-011 busy  out  1  high while state is not IDLE.
REQ-012 next_signal  out  1  one-cycle pulse: drop landed with overlap.
REQ-013 fail  out  1  one-cycle pulse: drop landed with no overlap.

Function
REQ-014 FSM states IDLE, SLIDE, RESOLVE; IDLE->SLIDE on start; SLIDE->RESOLVE on drop; RESOLVE->IDLE unconditionally.
REQ-015 On start in IDLE, width = num_blocks (0 treated as 1), period = speed_count (0 treated as 1) latched; pos = 0, dir = right, frame counter = 0.
REQ-016 start outside IDLE and drop outside SLIDE are ignored.
REQ-017 row_mask = ((1<<width)-1)<<pos in SLIDE and RESOLVE; 0 in IDLE.
REQ-018 In SLIDE each frame_tick increments frame counter; on the tick where counter = period-1, counter clears and pos steps one column in dir.
REQ-019 Bounce: at a step with dir right and pos = BOARD_W-width, dir flips and pos decrements; with dir left and pos = 0, dir flips and pos increments; width = BOARD_W holds pos at 0.
REQ-020 drop and a step in the same cycle: drop wins, pos not updated.
REQ-021 In RESOLVE, overlap = row_mask AND base_mask; nonzero -> next_signal = 1 and base_mask <= overlap; zero -> fail = 1 and base_mask <= all ones.
REQ-022 Latency: drop sampled at edge k, pulse asserted after edge k+1, deasserted after edge k+2; exactly one of next_signal/fail per drop.
REQ-023 busy and row_mask are registered-state decodes; no combinational path from inputs to outputs.

Reset
REQ-024 resetn low: state IDLE, pos 0, dir right, counter 0, row_mask 0, base_mask all ones, busy 0, next_signal 0, fail 0, immediately without clk.
REQ-025 resetn asserted mid-SLIDE or mid-RESOLVE discards the row; no pulse is emitted.

Structure
REQ-026 Shared package holds BOARD_W default, state encoding (IDLE=0, SLIDE=1, RESOLVE=2), and the direction constants.
REQ-027 One sub-module frame_divider: counts frame_tick to period, emits step pulse, clears on start.

Verification
REQ-028 Reset release -> row_mask 0x0000, base_mask 0xFFFF, busy 0, no pulses.
REQ-029 num_blocks 3, speed_count 2, start, 4 frame_ticks -> row_mask 0x0007 -> 0x000E -> 0x001C.
REQ-030 num_blocks 15, speed_count 1, start, 3 frame_ticks -> row_mask 0x7FFF, 0xFFFE, 0x7FFF, 0xFFFE.
REQ-031 Fresh base, num_blocks 3 at 0x001C, drop -> next_signal one cycle, base_mask 0x001C, busy drops.
REQ-032 base_mask 0x000F, row 0x00F0, drop -> fail one cycle, base_mask 0xFFFF.
REQ-033 drop coincident with step tick at 0x0007 -> base computed from 0x0007; resetn low mid-SLIDE -> row_mask 0 at once, no pulse.
